// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: instruction ROM port, redirect request and the decode dequeue handshake.
// The master modport belongs to fetch_queue. The slave modport belongs to the ROM and decode side.
interface fetch_queue_if;
   logic [15:0] imem_addr;
   logic [15:0] imem_instr;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        deq_ready;
   logic        deq_valid;
   logic [15:0] deq_instr;
   logic [15:0] deq_pc;
   logic        fetch_oob;

   modport master (
      output imem_addr,
      input  imem_instr,
      input  redirect_valid,
      input  redirect_pc,
      input  deq_ready,
      output deq_valid,
      output deq_instr,
      output deq_pc,
      output fetch_oob
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      output redirect_valid,
      output redirect_pc,
      output deq_ready,
      input  deq_valid,
      input  deq_instr,
      input  deq_pc,
      input  fetch_oob
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry circular queue of {instr, pc} feeding decode.
// It halts when the PC leaves the ROM. A redirect flushes the queue and restarts fetching.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          MEM_SIZE = 1024,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input logic          clk,
   input logic          reset_n,
   fetch_queue_if.master fq
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [16:0]      MEM_LIMIT  = 17'(MEM_SIZE);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t           state;
   logic [15:0]      pc;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [15:0]      instr_q [DEPTH];
   logic [15:0]      pc_q    [DEPTH];

   logic [16:0] pc_end;
   logic        in_bounds;
   logic        do_deq;
   logic        do_enq;

   // The bounds check is done in 17 bits so that a PC near 16'hFFFF cannot wrap back into range.
   assign pc_end    = {1'b0, pc} + 17'd3;
   assign in_bounds = (pc_end < MEM_LIMIT);
   assign do_deq    = (count != '0) && fq.deq_ready;
   assign do_enq    = (state == RUN) && in_bounds && !fq.redirect_valid &&
                      ((count < FULL_CNT) || do_deq);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
         pc    <= RESET_PC;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (fq.redirect_valid) begin
         state <= RUN;
         pc    <= {fq.redirect_pc[15:2], 2'b00};
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_deq) begin
            head <= head + PTR_ONE;
         end
         if (do_enq) begin
            tail <= tail + PTR_ONE;
            pc   <= pc + 16'd4;
         end
         if ((state == RUN) && !in_bounds) begin
            state <= HALT;
         end
         case ({do_enq, do_deq})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // The entry storage needs no reset. Count gates visibility, so stale data is never presented.
   always_ff @(posedge clk) begin
      if (do_enq) begin
         instr_q[tail] <= fq.imem_instr;
         pc_q[tail]    <= pc;
      end
   end

   assign fq.imem_addr = pc;
   assign fq.fetch_oob = (state == HALT);
   assign fq.deq_valid = (count != '0);
   assign fq.deq_instr = (count != '0) ? instr_q[head] : 16'h0000;
   assign fq.deq_pc    = (count != '0) ? pc_q[head]    : 16'h0000;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter MEM_SIZE, default 1024, meaning the instruction ROM size in bytes.
REQ-003 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port imem_addr, output, 16 bits: byte address driven to the instruction ROM; bits [1:0] are always 0.
REQ-007 Port imem_instr, input, 16 bits: combinational ROM data for imem_addr.
REQ-008 Port redirect_valid, input, 1 bit: branch/jump taken; flush and refetch.
REQ-009 Port redirect_pc, input, 16 bits: new fetch byte address.
REQ-010 Port deq_ready, input, 1 bit: decode stage accepts the head entry this cycle.
REQ-011 Port deq_valid, output, 1 bit: the head entry is valid.
REQ-012 Port deq_instr, output, 16 bits: instruction at the queue head.
REQ-013 Port deq_pc, output, 16 bits: byte address of deq_instr.
REQ-014 Port fetch_oob, output, 1 bit: fetch halted because the PC is out of ROM bounds.

Function
REQ-015 imem_addr SHALL equal the fetch PC register directly, with no combinational path from any input.
REQ-016 State machine SHALL have states RUN and HALT; reset enters RUN; fetch_oob = (state == HALT).
REQ-017 In RUN with PC + 3 >= MEM_SIZE, the block SHALL enter HALT next cycle without enqueuing; the PC SHALL hold.
REQ-018 HALT SHALL be left only by redirect_valid, which enters RUN with the new PC.
REQ-019 Dequeue SHALL occur on a cycle with deq_valid && deq_ready; the head pointer advances by 1 modulo DEPTH.
REQ-020 Enqueue SHALL occur when all four hold: state RUN, PC in bounds, no redirect_valid, and (count < DEPTH or a dequeue occurs the same cycle).
REQ-021 On enqueue: {imem_instr, PC} SHALL be written at the tail, the tail advances modulo DEPTH, and PC <= PC + 4.
REQ-022 Count SHALL be +1 on enqueue only, -1 on dequeue only, and unchanged on both or neither; it never exceeds DEPTH and never underflows.
REQ-023 deq_valid SHALL equal (count != 0); deq_instr and deq_pc SHALL reflect the head entry; when empty they SHALL read 0.
REQ-024 Latency: an instruction fetched in cycle N SHALL be presented on deq_* in cycle N+1; there is no same-cycle bypass.
REQ-025 While full and no dequeue occurs, PC and all entries SHALL hold (stall).
REQ-026 redirect_valid SHALL have priority over every other event, in RUN or HALT.
REQ-027 On redirect, count, head and tail SHALL reset to 0, PC <= {redirect_pc[15:2], 2'b00}, and state <= RUN.
REQ-028 A dequeue coinciding with a redirect SHALL be discarded; deq_valid SHALL be 0 the next cycle.
REQ-029 PC arithmetic SHALL be 16-bit unsigned; the bounds check SHALL use 17-bit PC + 3 so that wrap cannot mask out-of-bounds.

Reset
REQ-030 While reset_n = 0, asynchronously: PC = RESET_PC, imem_addr = RESET_PC, count/head/tail = 0, state = RUN, deq_valid = 0, deq_instr = 0, deq_pc = 0, fetch_oob = 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries immediately; fetching SHALL restart at RESET_PC on the first edge after release.

Verification
REQ-032 Reset release, deq_ready = 1, ROM[k] = k: deq_pc = 0,4,8,... and deq_instr = 0,1,2,..., one per cycle from cycle 1.
REQ-033 deq_ready = 0 for 6 cycles: count reaches 4 and PC holds at 16; deq_ready = 1 -> entries with deq_pc 0,4,8,12 then 16, with no gap.
REQ-034 Full queue, deq_ready = 1 and enqueue in the same cycle: count stays 4 and ordering is preserved.
REQ-035 redirect_valid with redirect_pc = 16'h0032 and 3 entries queued: next cycle deq_valid = 0 and imem_addr = 16'h0030; the cycle after, deq_pc = 16'h0030.
REQ-036 Fetch reaching PC = 1020 with MEM_SIZE = 1024: entry 1020 is enqueued, then PC = 1024 -> fetch_oob = 1 and no enqueue; redirect to 0 -> fetch_oob = 0.
REQ-037 reset_n pulsed low for half a cycle while 2 entries are queued: deq_valid = 0 immediately, and fetch resumes at RESET_PC.
